// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: MEM->WB bus layout and the
// commit-trace entry format.
package wb_stage_pkg;

   localparam int MEM2WB_BUS_W    = 102;
   localparam int REG_ADDR_BUS_W  = 5;
   localparam int REG_W           = 32;
   localparam int TRACE_ENTRY_W   = 70;

   localparam int BUS_PC_LSB      = 0;
   localparam int BUS_DM_ADDR_LSB = 32;
   localparam int BUS_RESULT_LSB  = 64;
   localparam int BUS_WE_BIT      = 96;
   localparam int BUS_WDEST_LSB   = 97;

   typedef struct packed {
      logic [REG_W-1:0]          pc;
      logic [REG_ADDR_BUS_W-1:0] waddr;
      logic [REG_W-1:0]          wdata;
      logic                      we;
   } trace_entry_t;

   // Writes to r0 are architectural no-ops and are never reported as writes.
   function automatic logic rf_write_req(input logic we, input logic [REG_ADDR_BUS_W-1:0] wdest);
      return we && (wdest != '0);
   endfunction

endpackage

// File: rtl/wb_stage_trace_fifo.sv
// Synchronous FIFO for commit-trace entries. When empty, rdata keeps showing
// the most recently popped entry instead of a stale slot.
module wb_stage_trace_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 70
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = 1;
   localparam logic [PW:0]   CNT_ONE  = 1;
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    last_ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // While empty, the slot behind rd_ptr is the last head and cannot have
   // been overwritten since it was popped.
   assign last_ptr = rd_ptr - PTR_ONE;
   assign empty    = (count == '0);
   assign full     = (count == CNT_FULL);
   assign rdata    = empty ? mem[last_ptr] : mem[rd_ptr];

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM->WB pipeline register, register-file write port,
// decode-side hazard/forward signals and an optional commit-trace FIFO.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int TRACE_DEPTH = 4,
   parameter bit TRACE_EN    = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [MEM2WB_BUS_W-1:0]   mem2wb_bus_i,
   input  logic                      ctl_mem_over_i,
   output logic                      ctl_wb_allowin_o,
   output logic                      rf_we_o,
   output logic [REG_ADDR_BUS_W-1:0] rf_waddr_o,
   output logic [REG_W-1:0]          rf_wdata_o,
   output logic [REG_ADDR_BUS_W-1:0] ctl_wb_dest_o,
   output logic [REG_W-1:0]          forward_wb2id_data_o,
   output logic [REG_W-1:0]          ctl_wb_pc_o,
   output logic                      trace_valid_o,
   input  logic                      trace_ready_i,
   output logic [REG_W-1:0]          trace_pc_o,
   output logic [REG_ADDR_BUS_W-1:0] trace_waddr_o,
   output logic [REG_W-1:0]          trace_wdata_o,
   output logic                      trace_we_o,
   output logic [REG_W-1:0]          commit_cnt_o
);

   logic                      wb_valid;
   logic                      wb_over;
   logic [MEM2WB_BUS_W-1:0]   bus_q;
   logic [REG_ADDR_BUS_W-1:0] wb_wdest;
   logic                      wb_we;
   logic [REG_W-1:0]          wb_result;
   logic [REG_W-1:0]          wb_pc;
   logic                      wb_rf_we;
   logic [REG_W-1:0]          commit_cnt;
   trace_entry_t              push_entry;
   logic                      unused_dm_addr;

   assign wb_wdest       = bus_q[BUS_WDEST_LSB +: REG_ADDR_BUS_W];
   assign wb_we          = bus_q[BUS_WE_BIT];
   assign wb_result      = bus_q[BUS_RESULT_LSB +: REG_W];
   assign wb_pc          = bus_q[BUS_PC_LSB +: REG_W];
   assign unused_dm_addr = ^bus_q[BUS_DM_ADDR_LSB +: REG_W];
   assign wb_rf_we       = rf_write_req(wb_we, wb_wdest);

   assign ctl_wb_allowin_o = !wb_valid || wb_over;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_valid   <= 1'b0;
         bus_q      <= '0;
         commit_cnt <= '0;
      end else begin
         if (ctl_wb_allowin_o) begin
            wb_valid <= ctl_mem_over_i;
            if (ctl_mem_over_i) begin
               bus_q <= mem2wb_bus_i;
            end
         end
         if (wb_over) begin
            commit_cnt <= commit_cnt + 32'd1;
         end
      end
   end

   // rst_n gate keeps an in-flight instruction from writing during the reset cycle.
   assign rf_we_o              = rst_n && wb_over && wb_rf_we;
   assign rf_waddr_o           = wb_wdest;
   assign rf_wdata_o           = wb_result;
   assign ctl_wb_dest_o        = wb_valid ? wb_wdest  : '0;
   assign forward_wb2id_data_o = wb_valid ? wb_result : '0;
   assign ctl_wb_pc_o          = wb_pc;
   assign commit_cnt_o         = commit_cnt;

   assign push_entry = '{pc: wb_pc, waddr: wb_wdest, wdata: wb_result, we: wb_rf_we};

   generate
      if (TRACE_EN) begin : g_trace
         logic                         fifo_full;
         logic                         fifo_empty;
         logic [$clog2(TRACE_DEPTH):0] fifo_count;
         logic                         trace_pop;
         trace_entry_t                 head;
         logic                         unused_fifo_count;

         wb_stage_trace_fifo #(
            .DEPTH (TRACE_DEPTH),
            .WIDTH (TRACE_ENTRY_W)
         ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (wb_over),
            .pop   (trace_pop),
            .wdata (push_entry),
            .rdata (head),
            .full  (fifo_full),
            .empty (fifo_empty),
            .count (fifo_count)
         );

         assign unused_fifo_count = ^fifo_count;
         assign trace_pop         = !fifo_empty && trace_ready_i;
         // A full FIFO still accepts a retirement when its head leaves this cycle.
         assign wb_over           = wb_valid && (!fifo_full || trace_pop);
         assign trace_valid_o     = !fifo_empty;
         assign trace_pc_o        = head.pc;
         assign trace_waddr_o     = head.waddr;
         assign trace_wdata_o     = head.wdata;
         assign trace_we_o        = head.we;
      end else begin : g_no_trace
         logic unused_trace;

         assign unused_trace  = ^{trace_ready_i, push_entry};
         assign wb_over       = wb_valid;
         assign trace_valid_o = 1'b0;
         assign trace_pc_o    = '0;
         assign trace_waddr_o = '0;
         assign trace_wdata_o = '0;
         assign trace_we_o    = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic checked
// against a queue-based model of retirement and the commit trace.
module tb_wb_stage;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  wd;
      logic        we;
      logic [31:0] res;
      logic [31:0] dm;
      logic [31:0] pc;
   } ins_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        we;
   } tr_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [101:0] mem2wb_bus;
   logic         ctl_mem_over;
   logic         ctl_wb_allowin;
   logic         rf_we;
   logic [4:0]   rf_waddr;
   logic [31:0]  rf_wdata;
   logic [4:0]   ctl_wb_dest;
   logic [31:0]  forward_wb2id_data;
   logic [31:0]  ctl_wb_pc;
   logic         trace_valid;
   logic         trace_ready;
   logic [31:0]  trace_pc;
   logic [4:0]   trace_waddr;
   logic [31:0]  trace_wdata;
   logic         trace_we;
   logic [31:0]  commit_cnt;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic        m_valid;
   ins_t        m_ins;
   tr_t         m_q[$];
   tr_t         m_last;
   logic [31:0] m_cnt;
   logic        e_over, e_allow, e_pop;
   logic        cur_mo;
   ins_t        cur_ins;

   wb_stage #(.TRACE_DEPTH(DEPTH), .TRACE_EN(1'b1)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .mem2wb_bus_i         (mem2wb_bus),
      .ctl_mem_over_i       (ctl_mem_over),
      .ctl_wb_allowin_o     (ctl_wb_allowin),
      .rf_we_o              (rf_we),
      .rf_waddr_o           (rf_waddr),
      .rf_wdata_o           (rf_wdata),
      .ctl_wb_dest_o        (ctl_wb_dest),
      .forward_wb2id_data_o (forward_wb2id_data),
      .ctl_wb_pc_o          (ctl_wb_pc),
      .trace_valid_o        (trace_valid),
      .trace_ready_i        (trace_ready),
      .trace_pc_o           (trace_pc),
      .trace_waddr_o        (trace_waddr),
      .trace_wdata_o        (trace_wdata),
      .trace_we_o           (trace_we),
      .commit_cnt_o         (commit_cnt)
   );

   always #5 clk = ~clk;

   function automatic ins_t rand_ins();
      ins_t r;
      r.wd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r.we  = 1'($urandom_range(0, 1));
      r.res = $urandom;
      r.dm  = $urandom;
      r.pc  = $urandom;
      return r;
   endfunction

   function automatic tr_t exp_head();
      return (m_q.size() > 0) ? m_q[0] : m_last;
   endfunction

   // Apply inputs just after the falling edge and derive this cycle's expectations.
   task automatic drive(input logic mo, input ins_t ins, input logic rdy);
      ctl_mem_over = mo;
      mem2wb_bus   = ins;
      trace_ready  = rdy;
      cur_mo       = mo;
      cur_ins      = ins;
      #1;
      e_pop   = (m_q.size() > 0) && rdy;
      e_over  = m_valid && ((m_q.size() < DEPTH) || e_pop);
      e_allow = !m_valid || e_over;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 1'b0;
         m_ins   = '0;
         m_q.delete();
         m_last  = '0;
         m_cnt   = '0;
      end else begin
         if (e_pop) m_last = m_q.pop_front();
         if (e_over) begin
            m_q.push_back('{pc: m_ins.pc, waddr: m_ins.wd, wdata: m_ins.res,
                            we: m_ins.we && (m_ins.wd != 5'd0)});
            m_cnt = m_cnt + 32'd1;
         end
         if (e_allow) begin
            m_valid = cur_mo;
            if (cur_mo) m_ins = cur_ins;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      drive(1'b0, '0, 1'b0);
      checks++; if (ctl_wb_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%0h exp=1", ctl_wb_allowin); end
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0h exp=0", rf_we); end
      checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL reset_trace_valid got=%0h exp=0", trace_valid); end
      checks++; if ({rf_waddr, rf_wdata, ctl_wb_dest, forward_wb2id_data, ctl_wb_pc} !== '0) begin
         failures++; $display("FAIL reset_wb_outputs got=%h exp=0", {rf_waddr, rf_wdata, ctl_wb_dest, forward_wb2id_data, ctl_wb_pc}); end
      checks++; if ({trace_pc, trace_waddr, trace_wdata, trace_we, commit_cnt} !== '0) begin
         failures++; $display("FAIL reset_trace_outputs got=%h exp=0", {trace_pc, trace_waddr, trace_wdata, trace_we, commit_cnt}); end
   endtask

   task automatic test_single();
      ins_t ins;
      ins = '{wd: 5'd5, we: 1'b1, res: 32'hDEADBEEF, dm: 32'h0, pc: 32'h1C000000};
      drive(1'b1, ins, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0);
      checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL single_rf_we got=%0h exp=1", rf_we); end
      checks++; if (rf_waddr !== 5'd5) begin failures++; $display("FAIL single_rf_waddr got=%0d exp=5", rf_waddr); end
      checks++; if (rf_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rf_wdata got=%h exp=deadbeef", rf_wdata); end
      checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL single_trace_early got=%0h exp=0", trace_valid); end
      tick();
      drive(1'b0, '0, 1'b1);
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL single_rf_we_once got=%0h exp=0", rf_we); end
      checks++; if (trace_valid !== 1'b1) begin failures++; $display("FAIL single_trace_valid got=%0h exp=1", trace_valid); end
      checks++; if ({trace_pc, trace_waddr, trace_wdata, trace_we} !== {32'h1C000000, 5'd5, 32'hDEADBEEF, 1'b1}) begin
         failures++; $display("FAIL single_trace_entry got=%h exp=%h", {trace_pc, trace_waddr, trace_wdata, trace_we}, {32'h1C000000, 5'd5, 32'hDEADBEEF, 1'b1}); end
      checks++; if (commit_cnt !== 32'd1) begin failures++; $display("FAIL single_commit_cnt got=%0d exp=1", commit_cnt); end
      tick();
      drive(1'b0, '0, 1'b0);
      checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL single_trace_drained got=%0h exp=0", trace_valid); end
      checks++; if (trace_pc !== 32'h1C000000) begin failures++; $display("FAIL single_trace_hold got=%h exp=1c000000", trace_pc); end
   endtask

   task automatic test_zero_dest();
      ins_t ins;
      ins = '{wd: 5'd0, we: 1'b1, res: 32'h12345678, dm: 32'h0, pc: 32'h1C000004};
      drive(1'b1, ins, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0);
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL zero_rf_we got=%0h exp=0", rf_we); end
      checks++; if (ctl_wb_dest !== 5'd0) begin failures++; $display("FAIL zero_dest got=%0d exp=0", ctl_wb_dest); end
      checks++; if (forward_wb2id_data !== 32'h12345678) begin failures++; $display("FAIL zero_forward got=%h exp=12345678", forward_wb2id_data); end
      tick();
      drive(1'b0, '0, 1'b1);
      checks++; if ({trace_valid, trace_we, trace_wdata} !== {1'b1, 1'b0, 32'h12345678}) begin
         failures++; $display("FAIL zero_trace got=%h exp=%h", {trace_valid, trace_we, trace_wdata}, {1'b1, 1'b0, 32'h12345678}); end
      checks++; if (commit_cnt !== 32'd2) begin failures++; $display("FAIL zero_commit_cnt got=%0d exp=2", commit_cnt); end
      tick();
   endtask

   task automatic test_back_to_back();
      ins_t seq[6];
      int   popped = 0;
      for (int i = 0; i < 6; i++) begin
         seq[i] = '{wd: 5'(i + 1), we: 1'b1, res: $urandom, dm: $urandom, pc: 32'h20000000 + 32'(i * 4)};
      end
      for (int c = 0; c < 5; c++) begin
         drive(1'b1, seq[c], 1'b0);
         checks++; if (ctl_wb_allowin !== 1'b1) begin failures++; $display("FAIL b2b_fill_allowin c=%0d got=%0h exp=1", c, ctl_wb_allowin); end
         tick();
      end
      for (int c = 0; c < 2; c++) begin
         drive(1'b1, seq[5], 1'b0);
         checks++; if (ctl_wb_allowin !== 1'b0) begin failures++; $display("FAIL b2b_stall_allowin c=%0d got=%0h exp=0", c, ctl_wb_allowin); end
         checks++; if (ctl_wb_dest !== seq[4].wd) begin failures++; $display("FAIL b2b_stall_dest got=%0d exp=%0d", ctl_wb_dest, seq[4].wd); end
         checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL b2b_stall_rf_we got=%0h exp=0", rf_we); end
         tick();
      end
      drive(1'b1, seq[5], 1'b1);
      checks++; if ({ctl_wb_allowin, rf_we, rf_waddr} !== {1'b1, 1'b1, seq[4].wd}) begin
         failures++; $display("FAIL b2b_release got=%h exp=%h", {ctl_wb_allowin, rf_we, rf_waddr}, {1'b1, 1'b1, seq[4].wd}); end
      checks++; if (trace_pc !== seq[0].pc) begin failures++; $display("FAIL b2b_order idx=0 got=%h exp=%h", trace_pc, seq[0].pc); end
      popped = 1;
      tick();
      for (int c = 0; c < 16; c++) begin
         drive(1'b0, '0, 1'b1);
         if (trace_valid === 1'b1 && popped < 6) begin
            checks++; if ({trace_pc, trace_wdata} !== {seq[popped].pc, seq[popped].res}) begin
               failures++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", popped, {trace_pc, trace_wdata}, {seq[popped].pc, seq[popped].res}); end
            popped++;
         end
         tick();
      end
      checks++; if (popped != 6) begin failures++; $display("FAIL b2b_pop_count got=%0d exp=6", popped); end
   endtask

   task automatic test_full_stream();
      logic [31:0] exp_pcs[$];
      int          n = 0;
      ins_t        ins;
      for (int c = 0; c < 5; c++) begin
         ins = '{wd: 5'd7, we: 1'b1, res: $urandom, dm: '0, pc: 32'h30000000 + 32'(n * 4)};
         exp_pcs.push_back(ins.pc);
         n++;
         drive(1'b1, ins, 1'b0);
         tick();
      end
      for (int c = 0; c < 8; c++) begin
         ins = '{wd: 5'd9, we: 1'b1, res: $urandom, dm: '0, pc: 32'h30000000 + 32'(n * 4)};
         exp_pcs.push_back(ins.pc);
         n++;
         drive(1'b1, ins, 1'b1);
         checks++; if ({ctl_wb_allowin, rf_we, trace_valid} !== 3'b111) begin
            failures++; $display("FAIL full_stream_flow c=%0d got=%b exp=111", c, {ctl_wb_allowin, rf_we, trace_valid}); end
         checks++; if (dut.g_trace.u_fifo.count !== 3'd4) begin
            failures++; $display("FAIL full_stream_count c=%0d got=%0d exp=4", c, dut.g_trace.u_fifo.count); end
         checks++; if (trace_pc !== exp_pcs[0]) begin failures++; $display("FAIL full_stream_order c=%0d got=%h exp=%h", c, trace_pc, exp_pcs[0]); end
         void'(exp_pcs.pop_front());
         tick();
      end
      for (int c = 0; c < 20; c++) begin
         drive(1'b0, '0, 1'b1);
         if (trace_valid === 1'b1) begin
            checks++; if (exp_pcs.size() == 0 || trace_pc !== exp_pcs[0]) begin
               failures++; $display("FAIL full_stream_drain got=%h left=%0d", trace_pc, exp_pcs.size()); end
            if (exp_pcs.size() > 0) void'(exp_pcs.pop_front());
         end
         tick();
      end
      checks++; if (exp_pcs.size() != 0) begin failures++; $display("FAIL full_stream_lost got=%0d exp=0", exp_pcs.size()); end
   endtask

   task automatic test_reset_mid();
      ins_t ins;
      for (int c = 0; c < 4; c++) begin
         ins = '{wd: 5'd3, we: 1'b1, res: $urandom, dm: '0, pc: 32'h40000000 + 32'(c * 4)};
         drive(1'b1, ins, 1'b0);
         tick();
      end
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0);
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rstmid_rf_we_in_reset got=%0h exp=0", rf_we); end
      tick();
      rst_n = 1'b1;
      drive(1'b0, '0, 1'b0);
      checks++; if ({trace_valid, rf_we, ctl_wb_allowin, ctl_wb_dest} !== {1'b0, 1'b0, 1'b1, 5'd0}) begin
         failures++; $display("FAIL rstmid_ctrl got=%h exp=%h", {trace_valid, rf_we, ctl_wb_allowin, ctl_wb_dest}, {1'b0, 1'b0, 1'b1, 5'd0}); end
      checks++; if (commit_cnt !== 32'd0) begin failures++; $display("FAIL rstmid_commit_cnt got=%0d exp=0", commit_cnt); end
   endtask

   task automatic test_wrap();
      ins_t ins;
      ins = '{wd: 5'd11, we: 1'b1, res: 32'hCAFE0001, dm: '0, pc: 32'h50000000};
      force dut.commit_cnt = 32'hFFFFFFFF;
      m_cnt = 32'hFFFFFFFF;
      drive(1'b1, ins, 1'b1);
      tick();
      release dut.commit_cnt;
      drive(1'b0, '0, 1'b1);
      checks++; if (commit_cnt !== 32'hFFFFFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffffffff", commit_cnt); end
      tick();
      drive(1'b0, '0, 1'b1);
      checks++; if (commit_cnt !== 32'h0) begin failures++; $display("FAIL wrap_commit_cnt got=%h exp=0", commit_cnt); end
      tick();
   endtask

   task automatic test_random();
      ins_t ins;
      tr_t  h;
      for (int c = 0; c < 400; c++) begin
         ins = rand_ins();
         drive(($urandom_range(0, 9) < 6), ins, 1'($urandom_range(0, 1)));
         h = exp_head();
         checks++; if (rf_we !== (e_over && m_ins.we && m_ins.wd != 5'd0)) begin
            failures++; $display("FAIL rand_rf_we c=%0d got=%0h exp=%0h", c, rf_we, e_over && m_ins.we && m_ins.wd != 5'd0); end
         checks++; if ({rf_waddr, rf_wdata, ctl_wb_pc} !== {m_ins.wd, m_ins.res, m_ins.pc}) begin
            failures++; $display("FAIL rand_rf_port c=%0d got=%h exp=%h", c, {rf_waddr, rf_wdata, ctl_wb_pc}, {m_ins.wd, m_ins.res, m_ins.pc}); end
         checks++; if (ctl_wb_allowin !== e_allow) begin failures++; $display("FAIL rand_allowin c=%0d got=%0h exp=%0h", c, ctl_wb_allowin, e_allow); end
         checks++; if ({ctl_wb_dest, forward_wb2id_data} !== (m_valid ? {m_ins.wd, m_ins.res} : 37'h0)) begin
            failures++; $display("FAIL rand_forward c=%0d got=%h exp=%h", c, {ctl_wb_dest, forward_wb2id_data}, m_valid ? {m_ins.wd, m_ins.res} : 37'h0); end
         checks++; if (trace_valid !== (m_q.size() > 0)) begin failures++; $display("FAIL rand_trace_valid c=%0d got=%0h exp=%0h", c, trace_valid, m_q.size() > 0); end
         checks++; if ({trace_pc, trace_waddr, trace_wdata, trace_we} !== h) begin
            failures++; $display("FAIL rand_trace_head c=%0d got=%h exp=%h", c, {trace_pc, trace_waddr, trace_wdata, trace_we}, h); end
         checks++; if (commit_cnt !== m_cnt) begin failures++; $display("FAIL rand_commit_cnt c=%0d got=%0d exp=%0d", c, commit_cnt, m_cnt); end
         tick();
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      ctl_mem_over = 1'b0;
      mem2wb_bus   = '0;
      trace_ready  = 1'b0;
      m_valid      = 1'b0;
      m_ins        = '0;
      m_last       = '0;
      m_cnt        = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_zero_dest();
      test_back_to_back();
      test_full_stream();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly downstream of the memory-access stage.
- Holds the MEM->WB pipeline register and drives the register-file write port.
- Generates WB-level hazard and forwarding signals for decode.
- Pushes every retired instruction into a small commit-trace FIFO with a ready/valid output. Trace backpressure stalls retirement.

Parameters:
- TRACE_DEPTH, 4, commit-trace FIFO entries; power of two, at least 2.
- TRACE_EN, 1, 1 = trace FIFO present; 0 = FIFO removed, trace_valid_o tied 0, retirement never stalls.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- mem2wb_bus_i  in  102  MEM->WB bus: [101:97] wdest, [96] we, [95:64] result, [63:32] dm addr (debug), [31:0] pc.
- ctl_mem_over_i  in  1  MEM stage holds a finished instruction this cycle.
- ctl_wb_allowin_o  out  1  WB register can accept a new instruction this cycle.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  5  register-file write address.
- rf_wdata_o  out  32  register-file write data.
- ctl_wb_dest_o  out  5  destination of the valid WB instruction, else 0.
- forward_wb2id_data_o  out  32  WB result when valid, else 0.
- ctl_wb_pc_o  out  32  pc of the instruction in WB.
- trace_valid_o  out  1  trace FIFO head valid.
- trace_ready_i  in  1  trace consumer accepts the head.
- trace_pc_o  out  32  head pc.
- trace_waddr_o  out  5  head write address.
- trace_wdata_o  out  32  head write data.
- trace_we_o  out  1  head register-write flag (0 when wdest = 0).
- commit_cnt_o  out  32  number of retired instructions.

Behaviour:
- Reset (rst_n = 0 at an edge): wb_valid = 0, bus register = 0, FIFO empty (rd/wr pointers and count = 0), commit_cnt_o = 0. Consequently all outputs are 0, except ctl_wb_allowin_o = 1.
- Retire condition:
  - wb_over = wb_valid && (count < TRACE_DEPTH || (trace_valid_o && trace_ready_i)).
  - A push into a full FIFO is legal only when a pop happens in the same cycle.
- Allow-in: ctl_wb_allowin_o = !wb_valid || wb_over. This is combinational from trace_ready_i; the path is accepted.
- Load of the WB register: when ctl_wb_allowin_o = 1, wb_valid <= ctl_mem_over_i; the bus register loads mem2wb_bus_i only if ctl_mem_over_i = 1. When ctl_wb_allowin_o = 0, the register holds.
- Latency: an instruction accepted at edge N retires in cycle N+1 at the earliest. Its register-file write commits at edge N+1, and its trace entry is visible at cycle N+2.
- rf_we_o = wb_over && we && (wdest != 0). rf_waddr_o = wdest and rf_wdata_o = result, both unconditionally from the register.
- ctl_wb_dest_o = wdest when wb_valid, else 0. forward_wb2id_data_o = result when wb_valid, else 0. Both remain asserted while WB is stalled by the trace FIFO.
- FIFO:
  - Push on wb_over with {pc, wdest, result, we && wdest != 0}.
  - Pop on trace_valid_o && trace_ready_i.
  - Pointers wrap modulo TRACE_DEPTH.
  - Simultaneous push and pop leaves count unchanged; push-while-full only with pop.
  - Empty FIFO: trace_valid_o = 0, trace data outputs hold the last head value.
- commit_cnt_o increments by 1 on every wb_over and wraps 0xFFFFFFFF -> 0.
- Reset mid-operation: all in-flight WB and FIFO contents are dropped, with no rf write in the reset cycle.
- TRACE_EN = 0: wb_over = wb_valid.

Decomposition:
- Shared header: MEM2WB bus size (102), field offsets, RegAddrBusW (5), RegW (32), trace entry width (70).
- Sub-module trace_fifo: parameterised synchronous FIFO with push/pop/full/empty/count, instantiated under TRACE_EN.

Test Plan:
- Reset, then send one instruction: pc 0x1C000000, wdest 5, we 1, result 0xDEADBEEF.
  - Expected: rf_we_o = 1 for exactly one cycle, waddr 5, wdata 0xDEADBEEF.
  - Expected: trace entry appears next cycle; commit_cnt_o = 1.
- Send an instruction with wdest 0, we 1, result 0x12345678.
  - Expected: rf_we_o stays 0, ctl_wb_dest_o = 0.
  - Expected: trace entry has trace_we_o = 0.
- trace_ready_i = 0, stream 6 back-to-back instructions, TRACE_DEPTH 4.
  - Expected: after 4 retire, the 5th sits in WB with ctl_wb_allowin_o = 0 and ctl_wb_dest_o held.
  - Expected: raising trace_ready_i retires it in that same cycle (push with pop when full).
  - Expected: the 6 trace entries come out in order.
- Trace full with trace_ready_i = 1 continuously.
  - Expected: one retire per cycle, count constant at 4, no entry lost.
- Assert rst_n = 0 for one cycle while WB is valid and FIFO holds 3 entries.
  - Expected: next cycle trace_valid_o = 0, rf_we_o = 0, commit_cnt_o = 0, allowin = 1.
- Preload commit_cnt to 0xFFFFFFFF via force, then retire one instruction.
  - Expected: commit_cnt_o = 0x00000000.
